// File: rtl/card_pkg.sv
// Shared widths, status encodings and scan states for the card board.
package card_pkg;

  localparam int LOC_W     = 4;
  localparam int VAL_W     = 4;
  localparam int NUM_CARDS = 2 ** LOC_W;
  localparam int ENTRY_W   = VAL_W + 2;

  localparam logic [1:0] ST_FACEUP  = 2'b00;
  localparam logic [1:0] ST_HIDDEN  = 2'b01;
  localparam logic [1:0] ST_REMOVED = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  // Power-up / reset image of every board entry: hidden, value 0.
  localparam logic [ENTRY_W-1:0] ENTRY_RESET = {ST_HIDDEN, {VAL_W{1'b0}}};

  typedef enum logic [3:0] {
    SCAN_IDLE    = 4'b0001,
    SCAN_FETCH   = 4'b0010,
    SCAN_PRESENT = 4'b0100,
    SCAN_DONE    = 4'b1000
  } scan_state_e;

  // The renderer never sees an illegal status; it is drawn as a hidden card.
  function automatic logic [ENTRY_W-1:0] tile_code(input logic [ENTRY_W-1:0] entry);
    if (entry[ENTRY_W-1 -: 2] == ST_ILLEGAL) begin
      return {ST_HIDDEN, entry[VAL_W-1:0]};
    end
    return entry;
  endfunction

  function automatic logic is_removed(input logic [ENTRY_W-1:0] entry);
    return entry[ENTRY_W-1 -: 2] == ST_REMOVED;
  endfunction

endpackage

// File: rtl/card_board_reader_if.sv
// Tile stream from the board scanner to the tile renderer.
interface card_board_reader_if;
  import card_pkg::*;

  logic               TileValid;
  logic               TileReady;
  logic [LOC_W-1:0]   TileLoc;
  logic [ENTRY_W-1:0] TileCode;
  logic               TileCursor;

  // Scanner side.
  modport master (
    output TileValid,
    output TileLoc,
    output TileCode,
    output TileCursor,
    input  TileReady
  );

  // Renderer side.
  modport slave (
    input  TileValid,
    input  TileLoc,
    input  TileCode,
    input  TileCursor,
    output TileReady
  );

endinterface

// File: rtl/card_board_regfile.sv
// 16-entry board storage: one write port, two write-first read ports,
// plus a raw (pre-write) view of the entry being written.
module card_board_regfile
  import card_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               WriteEnable,
  input  logic [LOC_W-1:0]   WrLoc,
  input  logic [ENTRY_W-1:0] WrData,
  input  logic [LOC_W-1:0]   RdLocA,
  output logic [ENTRY_W-1:0] RdDataA,
  input  logic [LOC_W-1:0]   RdLocB,
  output logic [ENTRY_W-1:0] RdDataB,
  output logic [ENTRY_W-1:0] WrOldData
);

  logic [ENTRY_W-1:0] entry_reg [NUM_CARDS];

  // Entry storage; every entry returns to the hidden/0 image on reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_CARDS; i++) begin
        entry_reg[i] <= ENTRY_RESET;
      end
    end else if (WriteEnable) begin
      entry_reg[WrLoc] <= WrData;
    end
  end

  // A same-cycle write to the read location is forwarded so readers see the new entry.
  assign RdDataA   = (WriteEnable && (WrLoc == RdLocA)) ? WrData : entry_reg[RdLocA];
  assign RdDataB   = (WriteEnable && (WrLoc == RdLocB)) ? WrData : entry_reg[RdLocB];
  // Old contents at the write location, used to track removed-card bookkeeping.
  assign WrOldData = entry_reg[WrLoc];

endmodule

// File: rtl/card_board_reader.sv
// Card board: storage written by gameplay_sm, cursor readback, and a
// once-per-frame valid/ready scan of all entries to the tile renderer.
module card_board_reader
  import card_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                WriteEnable,
  input  logic [LOC_W-1:0]    WrLoc,
  input  logic [ENTRY_W-1:0]  WrData,
  input  logic [LOC_W-1:0]    CursorLoc,
  output logic [ENTRY_W-1:0]  CardSelectData,
  output logic [LOC_W-1:0]    CardSelectLoc,
  input  logic                FrameStart,
  card_board_reader_if.master tile,
  output logic                ScanDone,
  output logic [LOC_W:0]      RemovedCount,
  output logic                StatusErr
);

  scan_state_e        state_reg;
  logic [LOC_W-1:0]   idx_reg;
  logic [ENTRY_W-1:0] cursor_rd;
  logic [ENTRY_W-1:0] scan_rd;
  logic [ENTRY_W-1:0] wr_old;
  logic               old_removed;
  logic               new_removed;

  card_board_regfile u_regfile (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .WriteEnable(WriteEnable),
    .WrLoc      (WrLoc),
    .WrData     (WrData),
    .RdLocA     (CursorLoc),
    .RdDataA    (cursor_rd),
    .RdLocB     (idx_reg),
    .RdDataB    (scan_rd),
    .WrOldData  (wr_old)
  );

  assign old_removed = is_removed(wr_old);
  assign new_removed = is_removed(WrData);

  // Cursor readback, one cycle behind CursorLoc.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      CardSelectData <= ENTRY_RESET;
      CardSelectLoc  <= '0;
    end else begin
      CardSelectData <= cursor_rd;
      CardSelectLoc  <= CursorLoc;
    end
  end

  // Removed-card count follows status transitions into and out of "removed".
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RemovedCount <= '0;
    end else if (WriteEnable) begin
      if (!old_removed && new_removed) begin
        RemovedCount <= RemovedCount + 1'b1;
      end else if (old_removed && !new_removed) begin
        RemovedCount <= RemovedCount - 1'b1;
      end
    end
  end

  // Sticky flag for any illegal status written by gameplay.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      StatusErr <= 1'b0;
    end else if (WriteEnable && (WrData[ENTRY_W-1 -: 2] == ST_ILLEGAL)) begin
      StatusErr <= 1'b1;
    end
  end

  // Scan FSM: fetch one entry, hold it until the renderer takes it, repeat 16 times.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg       <= SCAN_IDLE;
      idx_reg         <= '0;
      tile.TileValid  <= 1'b0;
      tile.TileLoc    <= '0;
      tile.TileCode   <= '0;
      tile.TileCursor <= 1'b0;
      ScanDone        <= 1'b0;
    end else begin
      ScanDone <= 1'b0;
      case (state_reg)
        SCAN_IDLE: begin
          if (FrameStart) begin
            idx_reg   <= '0;
            state_reg <= SCAN_FETCH;
          end
        end
        SCAN_FETCH: begin
          tile.TileCode   <= tile_code(scan_rd);
          tile.TileLoc    <= idx_reg;
          tile.TileCursor <= (idx_reg == CursorLoc);
          tile.TileValid  <= 1'b1;
          state_reg       <= SCAN_PRESENT;
        end
        SCAN_PRESENT: begin
          if (tile.TileValid && tile.TileReady) begin
            tile.TileValid <= 1'b0;
            if (idx_reg == LOC_W'(NUM_CARDS - 1)) begin
              ScanDone  <= 1'b1;
              state_reg <= SCAN_DONE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= SCAN_FETCH;
            end
          end
        end
        SCAN_DONE: begin
          state_reg <= SCAN_IDLE;
        end
        default: begin
          tile.TileValid <= 1'b0;
          state_reg      <= SCAN_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_board_reader.sv
// Directed bench for card_board_reader with a tile-stream scoreboard.
module tb_card_board_reader;
  import card_pkg::*;

  logic                Clk = 1'b0;
  logic                Reset_n = 1'b1;
  logic                WriteEnable = 1'b0;
  logic [LOC_W-1:0]    WrLoc = '0;
  logic [ENTRY_W-1:0]  WrData = '0;
  logic [LOC_W-1:0]    CursorLoc = '0;
  logic                FrameStart = 1'b0;
  logic [ENTRY_W-1:0]  CardSelectData;
  logic [LOC_W-1:0]    CardSelectLoc;
  logic                ScanDone;
  logic [LOC_W:0]      RemovedCount;
  logic                StatusErr;

  card_board_reader_if tile ();

  card_board_reader dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .WriteEnable   (WriteEnable),
    .WrLoc         (WrLoc),
    .WrData        (WrData),
    .CursorLoc     (CursorLoc),
    .CardSelectData(CardSelectData),
    .CardSelectLoc (CardSelectLoc),
    .FrameStart    (FrameStart),
    .tile          (tile),
    .ScanDone      (ScanDone),
    .RemovedCount  (RemovedCount),
    .StatusErr     (StatusErr)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int scans_done = 0;
  logic pend_done = 1'b0;
  logic [10:0] exp_q [$];            // {cursor, loc[3:0], code[5:0]}
  logic [ENTRY_W-1:0] model [NUM_CARDS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] loc, input logic [5:0] data);
    WriteEnable = 1'b1;
    WrLoc = loc;
    WrData = data;
    step();
    WriteEnable = 1'b0;
    model[loc] = data;
    $display("write loc=%0d data=%b removed=%0d err=%b", loc, data, RemovedCount, StatusErr);
  endtask

  task automatic start_frame();
    FrameStart = 1'b1;
    step();
    FrameStart = 1'b0;
  endtask

  // Expected tiles first..last from the model; an illegal status is shown as hidden.
  task automatic push_tiles(input int first, input int last, input logic [3:0] cur);
    logic [5:0] c;
    for (int i = first; i <= last; i++) begin
      c = model[i];
      if (c[5:4] == 2'b11) c[5:4] = 2'b01;
      exp_q.push_back({(4'(i) == cur), 4'(i), c});
    end
  endtask

  task automatic wait_scan(input int target);
    int cyc = 0;
    while ((exp_q.size() != 0 || scans_done < target) && cyc < 200) begin
      step();
      cyc++;
    end
    check("scan_queue_drained", exp_q.size(), 0);
    check("scan_count", scans_done, target);
  endtask

  task automatic wait_tile(input logic [3:0] loc);
    int cyc = 0;
    while (!(tile.TileValid && tile.TileLoc == loc) && cyc < 100) begin
      step();
      cyc++;
    end
    check("wait_tile_valid", tile.TileValid, 1);
    check("wait_tile_loc", tile.TileLoc, loc);
  endtask

  // Monitor: pops the scoreboard on each accepted tile and checks ScanDone timing.
  always @(negedge Clk) begin
    logic [10:0] e;
    if (pend_done) begin
      check("scan_done_pulse", ScanDone, 1);
      pend_done = 1'b0;
      scans_done++;
    end else if (ScanDone) begin
      check("scan_done_spurious", ScanDone, 0);
    end
    if (tile.TileValid === 1'b1 && tile.TileReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_tile: got loc=%0d code=%b expected no tile", tile.TileLoc, tile.TileCode);
      end else begin
        e = exp_q.pop_front();
        check("tile_loc", tile.TileLoc, e[9:6]);
        check("tile_code", tile.TileCode, e[5:0]);
        check("tile_cursor", tile.TileCursor, e[10]);
        $display("tile loc=%0d code=%b cursor=%b", tile.TileLoc, tile.TileCode, tile.TileCursor);
      end
      if (tile.TileLoc == 4'd15) pend_done = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tile.TileReady = 1'b1;
    for (int i = 0; i < NUM_CARDS; i++) model[i] = 6'b01_0000;

    // Reset state
    #2 Reset_n = 1'b0;
    repeat (3) step();
    Reset_n = 1'b1;
    step();
    check("rst_tile_valid", tile.TileValid, 0);
    check("rst_scan_done", ScanDone, 0);
    check("rst_removed", RemovedCount, 0);
    check("rst_status_err", StatusErr, 0);
    check("rst_card_data", CardSelectData, 6'b01_0000);
    check("rst_card_loc", CardSelectLoc, 0);

    // 1: full scan after reset, all hidden/0, cursor on loc 0
    CursorLoc = 4'd0;
    push_tiles(0, 15, 4'd0);
    start_frame();
    wait_scan(1);
    check("t1_removed", RemovedCount, 0);

    // 2: removed-count bookkeeping
    write_entry(4'd5, 6'b10_0011);
    check("t2_removed_a", RemovedCount, 1);
    write_entry(4'd9, 6'b10_0011);
    check("t2_removed_b", RemovedCount, 2);
    write_entry(4'd5, 6'b10_0011);
    check("t2_removed_rewrite", RemovedCount, 2);
    write_entry(4'd5, 6'b01_0011);
    check("t2_removed_dec", RemovedCount, 1);

    // 3: cursor read with same-cycle write bypass
    CursorLoc = 4'd7;
    WriteEnable = 1'b1;
    WrLoc = 4'd7;
    WrData = 6'b00_1010;
    step();
    WriteEnable = 1'b0;
    model[7] = 6'b00_1010;
    check("t3_bypass_data", CardSelectData, 6'b00_1010);
    check("t3_bypass_loc", CardSelectLoc, 7);
    CursorLoc = 4'd5;
    step();
    check("t3_cursor5_data", CardSelectData, 6'b01_0011);
    check("t3_cursor5_loc", CardSelectLoc, 5);

    // 4: stall on tile 3 while writing loc 3 and loc 4
    push_tiles(0, 15, 4'd5);
    exp_q[4] = {1'b0, 4'd4, 6'b00_1100};   // loc 4 written before its fetch
    start_frame();
    wait_tile(4'd3);
    tile.TileReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        WriteEnable = 1'b1; WrLoc = 4'd3; WrData = 6'b00_0001;
      end else if (i == 1) begin
        WriteEnable = 1'b1; WrLoc = 4'd4; WrData = 6'b00_1100;
      end
      step();
      WriteEnable = 1'b0;
      check("t4_hold_valid", tile.TileValid, 1);
      check("t4_hold_loc", tile.TileLoc, 3);
      check("t4_hold_code", tile.TileCode, 6'b01_0000);
    end
    model[3] = 6'b00_0001;
    model[4] = 6'b00_1100;
    tile.TileReady = 1'b1;
    wait_scan(2);
    check("t4_removed", RemovedCount, 1);

    // 5: FrameStart mid-scan ignored, then reset at tile 8
    push_tiles(0, 7, 4'd5);
    start_frame();
    wait_tile(4'd3);
    FrameStart = 1'b1;
    step();
    FrameStart = 1'b0;
    wait_tile(4'd8);
    Reset_n = 1'b0;
    #1;
    check("t5_async_valid", tile.TileValid, 0);
    check("t5_tiles_0_7_seen", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < NUM_CARDS; i++) model[i] = 6'b01_0000;
    step();
    Reset_n = 1'b1;
    step();
    check("t5_removed", RemovedCount, 0);
    check("t5_status_err", StatusErr, 0);
    check("t5_card_data", CardSelectData, 6'b01_0000);
    check("t5_valid_idle", tile.TileValid, 0);

    // 6: illegal status write; scan also confirms every entry was reset
    write_entry(4'd2, 6'b11_0001);
    check("t6_status_err", StatusErr, 1);
    check("t6_removed", RemovedCount, 0);
    CursorLoc = 4'd2;
    step();
    check("t6_card_raw", CardSelectData, 6'b11_0001);
    CursorLoc = 4'd5;
    push_tiles(0, 15, 4'd5);
    start_frame();
    wait_scan(3);
    check("t6_status_sticky", StatusErr, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
